// File: rtl/demux_route_pkg.sv
// Shared types for the demux route sequencer: default widths, FSM states and
// the packed FIFO entry layout {dest, data}.
package demux_route_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_SEL_W  = 2;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic [DEF_SEL_W-1:0]  dest;
      logic [DEF_DATA_W-1:0] data;
   } route_entry_t;

endpackage

// File: rtl/route_fifo.sv
// Small synchronous FIFO with flush and occupancy output. Reads are never
// bypassed: a word becomes visible on rd_data only the cycle after its push.
module route_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LVL_W'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/demux_route_sequencer.sv
// Feeds the 1:4 demux: buffers tagged words and presents each one on
// select/data_out for HOLD_CYCLES cycles, back-to-back when words are queued.
module demux_route_sequencer
   import demux_route_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SEL_W       = DEF_SEL_W,
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [SEL_W-1:0]           in_dest,
   input  logic                       rr_mode,
   input  logic                       flush,
   output logic [SEL_W-1:0]           select,
   output logic [DATA_W-1:0]          data_out,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [SEL_W-1:0]          rr_q, rr_d;
   logic [SEL_W-1:0]          select_q, select_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [SEL_W+DATA_W-1:0]   rd_entry;

   assign in_ready  = !fifo_full;
   assign select    = select_q;
   assign data_out  = data_q;
   assign out_valid = valid_q;

   route_fifo #(
      .WIDTH (SEL_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid),
      .wr_data ({in_dest, in_data}),
      .pop     (pop),
      .flush   (flush),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   // Next word is popped on the same edge the previous dwell ends, so the
   // demux sees no idle gap between queued words.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      select_d = select_q;
      data_d   = data_q;
      valid_d  = valid_q;
      pop      = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         rr_d    = '0;
         data_d  = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pop = !fifo_empty;
            end
            ST_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  data_d  = '0;
                  valid_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (pop) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
            valid_d = 1'b1;
            data_d  = rd_entry[DATA_W-1:0];
            if (rr_mode) begin
               select_d = rr_q;
               rr_d     = rr_q + 1'b1;
            end else begin
               select_d = rd_entry[SEL_W+DATA_W-1:DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rr_q     <= '0;
         select_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         select_q <= select_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

endmodule
